hazard_stall_unit: RTL and testbench

Decode-stage stall controller that pairs with the EX-stage forwarding logic: it stalls the cases forwarding cannot resolve. It detects load-use hazards and inserts one bubble. It also sequences the multi-cycle multiply/divide unit, holding any dependent instruction in ID until HI/LO are valid. It drives the PC / IF-ID write enables and the ID/EX bubble select, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_stall_unit_pkg.sv | 30 +++
 rtl/hazard_stall_unit_md_busy_counter.sv | 50 +++++
 rtl/hazard_stall_unit.sv | 64 ++++++
 tb/tb_hazard_stall_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared pipeline constants for the decode-stage stall controller
package hazard_stall_unit_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [4:0] REG_ZERO           = 5'd0;
   localparam int         MD_LATENCY_DEFAULT = 32;

   // SPECIAL-opcode funct codes that decode maps onto IDmuldiv / IDreadsHiLo
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;

   function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_SPECIAL) &&
             (fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
   endfunction

   function automatic logic is_read_hilo(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_SPECIAL) && (fn == FN_MFHI || fn == FN_MFLO);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// rtl/hazard_stall_unit_md_busy_counter.sv - mult/div busy FSM and latency down-counter
module hazard_stall_unit_md_busy_counter
   import hazard_stall_unit_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic md_busy
);

   localparam int                MD_CNT_W = $clog2(MD_LATENCY);
   localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 1);

   md_state_e             state_q, state_d;
   logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = MD_BUSY;
               md_cnt_d = CNT_LOAD;
            end
         end
         MD_BUSY: begin
            // HI/LO are written on the edge that leaves this state
            if (md_cnt_q != '0) md_cnt_d = md_cnt_q - 1'b1;
            else                state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use and mult/div dependency stall controller for the ID stage
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IFIDRs,
   input  logic [4:0]       IFIDRt,
   input  logic [4:0]       IDEXRt,
   input  logic             IDEXmemread,
   input  logic             IDmuldiv,
   input  logic             IDreadsHiLo,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXBubble,
   output logic             md_start,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   logic             busy_q;
   logic             load_use, md_hold, stall;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   hazard_stall_unit_md_busy_counter #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_busy_counter (
      .clk     (clk),
      .rst     (rst),
      .start   (md_start),
      .md_busy (busy_q)
   );

   always_comb begin
      load_use = IDEXmemread && (IDEXRt != REG_ZERO) &&
                 ((IDEXRt == IFIDRs) || (IDEXRt == IFIDRt));
      md_hold  = busy_q && (IDmuldiv || IDreadsHiLo);
      stall    = load_use || md_hold;
   end

   // A load-use hazard on a mult/div operand defers its start until the bubble is in
   assign md_start   = !rst && !busy_q && IDmuldiv && !load_use;
   assign PCWrite    = !rst && !stall;
   assign IFIDWrite  = !rst && !stall;
   assign IDEXBubble = rst || stall;
   assign md_busy    = busy_q && !rst;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != {CNT_W{1'b1}}))
         stall_cycles_d = stall_cycles_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cycles_q <= '0;
      else     stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - vector table and scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

   localparam int MD_LATENCY = 4;
   localparam int CNT_W      = 4;

   typedef struct {
      logic       rst, mr;
      logic [4:0] exrt, rs, rt;
      logic       md, hl;
      logic       pcw, bub, start, busy;
      logic [CNT_W-1:0] cnt;
   } vec_t;

   typedef struct {
      logic             pcw, bub, start, busy;
      logic [CNT_W-1:0] cnt;
      int               idx;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [4:0]       IFIDRs = '0, IFIDRt = '0, IDEXRt = '0;
   logic             IDEXmemread = 1'b0, IDmuldiv = 1'b0, IDreadsHiLo = 1'b0;
   logic             PCWrite, IFIDWrite, IDEXBubble, md_start, md_busy;
   logic [CNT_W-1:0] stall_cycles;

   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   hazard_stall_unit #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .IFIDRs       (IFIDRs),
      .IFIDRt       (IFIDRt),
      .IDEXRt       (IDEXRt),
      .IDEXmemread  (IDEXmemread),
      .IDmuldiv     (IDmuldiv),
      .IDreadsHiLo  (IDreadsHiLo),
      .PCWrite      (PCWrite),
      .IFIDWrite    (IFIDWrite),
      .IDEXBubble   (IDEXBubble),
      .md_start     (md_start),
      .md_busy      (md_busy),
      .stall_cycles (stall_cycles)
   );

   task automatic add(input logic r, input logic mr, input logic [4:0] exrt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic md,
                      input logic hl, input logic pcw, input logic start,
                      input logic busy, input int cnt);
      vec_t v;
      v.rst = r;  v.mr = mr; v.exrt = exrt; v.rs = rs; v.rt = rt;
      v.md = md;  v.hl = hl; v.pcw = pcw;   v.bub = ~pcw;
      v.start = start; v.busy = busy; v.cnt = CNT_W'(cnt);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
   endtask

   task automatic drive_and_push(input vec_t v, input int idx);
      exp_t e;
      @(posedge clk); #1;
      rst = v.rst; IDEXmemread = v.mr; IDEXRt = v.exrt;
      IFIDRs = v.rs; IFIDRt = v.rt; IDmuldiv = v.md; IDreadsHiLo = v.hl;
      e.pcw = v.pcw; e.bub = v.bub; e.start = v.start; e.busy = v.busy;
      e.cnt = v.cnt; e.idx = idx;
      sb.push_back(e);
   endtask

   task automatic pop_and_check();
      exp_t e;
      @(negedge clk);
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      chk("PCWrite",      e.idx, 32'(PCWrite),      32'(e.pcw));
      chk("IFIDWrite",    e.idx, 32'(IFIDWrite),    32'(e.pcw));
      chk("IDEXBubble",   e.idx, 32'(IDEXBubble),   32'(e.bub));
      chk("md_start",     e.idx, 32'(md_start),     32'(e.start));
      chk("md_busy",      e.idx, 32'(md_busy),      32'(e.busy));
      chk("stall_cycles", e.idx, 32'(stall_cycles), 32'(e.cnt));
   endtask

   initial begin
      //   rst mr exrt rs rt md hl | pcw start busy cnt
      add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);    // reset state
      // load-use: one bubble, rt match, zero register, no match
      add(0, 1, 8, 8, 0, 0, 0,  0, 0, 0, 0);
      add(0, 0, 8, 8, 0, 0, 0,  1, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1);
      add(0, 1, 8, 0, 8, 0, 0,  0, 0, 0, 1);
      add(0, 1, 9, 8, 8, 0, 0,  1, 0, 0, 2);
      // mult then mfhi held for the whole busy window
      add(0, 0, 0, 1, 2, 1, 0,  1, 1, 0, 2);
      add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 2);
      add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 3);
      add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 4);
      add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 5);
      add(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 6);
      // independent instructions flow during busy; load-use still stalls
      add(0, 0, 0, 1, 2, 1, 0,  1, 1, 0, 6);
      add(0, 0, 0, 3, 4, 0, 0,  1, 0, 1, 6);
      add(0, 0, 0, 3, 4, 0, 0,  1, 0, 1, 6);
      add(0, 1, 5, 5, 4, 0, 0,  0, 0, 1, 6);
      add(0, 0, 0, 3, 4, 0, 0,  1, 0, 1, 7);
      add(0, 0, 0, 3, 4, 0, 0,  1, 0, 0, 7);
      // load-use on a mult operand: bubble, then start, full latency
      add(0, 1, 6, 6, 0, 1, 0,  0, 0, 0, 7);
      add(0, 0, 6, 6, 0, 1, 0,  1, 1, 0, 8);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 8);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 8);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 8);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 8);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 8);
      // back-to-back div: second start five cycles after the first
      add(0, 0, 0, 1, 2, 1, 0,  1, 1, 0, 8);
      add(0, 0, 0, 1, 2, 1, 0,  0, 0, 1, 8);
      add(0, 0, 0, 1, 2, 1, 0,  0, 0, 1, 9);
      add(0, 0, 0, 1, 2, 1, 0,  0, 0, 1, 10);
      add(0, 0, 0, 1, 2, 1, 0,  0, 0, 1, 11);
      add(0, 0, 0, 1, 2, 1, 0,  1, 1, 0, 12);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 12);
      // reset in the second busy cycle abandons the op, new mult starts at once
      add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12);
      add(0, 0, 0, 1, 2, 1, 0,  1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0);
      add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);

      repeat (2) @(posedge clk);
      foreach (vecs[i]) begin
         drive_and_push(vecs[i], i);
         pop_and_check();
      end

      // sustained load-use stall: counter saturates at all-ones, never wraps
      for (int i = 0; i < 24; i++) begin
         vec_t v;
         v.rst = 0; v.mr = 1; v.exrt = 5'd8; v.rs = 5'd8; v.rt = 5'd0;
         v.md = 0; v.hl = 0; v.pcw = 0; v.bub = 1; v.start = 0; v.busy = 0;
         v.cnt = (i > 15) ? CNT_W'(15) : CNT_W'(i);
         drive_and_push(v, 100 + i);
         pop_and_check();
      end

      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
